// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-RAM arbiter.
//   state_t  : arbiter FSM states (IDLE = single-cycle grants, BURST = display owns RAM)
//   req_id_t : requester identifiers used for the grant and the round-robin pointer
package dmem_arb_pkg;
    localparam int DEF_AW        = 8;
    localparam int DEF_DW        = 8;
    localparam int DEF_MAX_WAIT  = 4;
    localparam int DEF_BURST_LEN = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_CPU  = 2'd1,
        REQ_DISP = 2'd2,
        REQ_KBD  = 2'd3
    } req_id_t;
endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Starvation counter for one secondary requester.
//   CLK, RESET : clock, synchronous active-high reset
//   req        : requester is asking for the RAM this cycle
//   gnt        : requester is granted this cycle
//   starved    : requester has waited MAX_WAIT cycles and must get the next slot
module starve_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic req,
    input  logic gnt,
    output logic starved
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] r_cnt;

    // Counts ungranted request cycles, saturating; a grant clears it.
    always_ff @(posedge CLK) begin
        if (RESET)
            r_cnt <= '0;
        else if (gnt)
            r_cnt <= '0;
        else if (req && (r_cnt != CW'(MAX_WAIT)))
            r_cnt <= r_cnt + 1'b1;
    end

    assign starved = (r_cnt == CW'(MAX_WAIT));
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port async-read data RAM between the CPU (priority),
// the display burst reader and the keypad writer (round-robin, starvation-bounded).
//   CPU    : cpu_re/cpu_we/cpu_addr/cpu_wdata in, cpu_rdata/cpu_stall out (combinational)
//   Display: disp_req/disp_addr in, disp_ack (comb) and registered disp_rvalid/rdata/last
//   Keypad : kbd_req/kbd_addr/kbd_wdata in, kbd_ack out (comb, write lands same cycle)
//   RAM    : ram_addr/ram_wdata/ram_we out, ram_rdata in
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_ack,
    output logic          disp_rvalid,
    output logic [DW-1:0] disp_rdata,
    output logic          disp_last,
    input  logic          kbd_req,
    input  logic [AW-1:0] kbd_addr,
    input  logic [DW-1:0] kbd_wdata,
    output logic          kbd_ack,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    state_t        r_state, w_state_nxt;
    req_id_t       w_gnt;
    req_id_t       r_rr_ptr;
    logic [BW-1:0] r_beat;
    logic [AW-1:0] r_disp_addr;
    logic          r_rvalid, r_last;
    logic [DW-1:0] r_rdata;
    logic          w_cpu_req, w_disp_starved, w_kbd_starved;
    logic          w_disp_gnt, w_kbd_gnt;
    logic          w_beat_issue, w_beat_last;

    assign w_cpu_req  = cpu_re | cpu_we;
    assign w_disp_gnt = (w_gnt == REQ_DISP);
    assign w_kbd_gnt  = (w_gnt == REQ_KBD);

    starve_counter #(.MAX_WAIT(MAX_WAIT)) u_disp_starve (
        .CLK(CLK), .RESET(RESET), .req(disp_req), .gnt(w_disp_gnt), .starved(w_disp_starved)
    );
    starve_counter #(.MAX_WAIT(MAX_WAIT)) u_kbd_starve (
        .CLK(CLK), .RESET(RESET), .req(kbd_req), .gnt(w_kbd_gnt), .starved(w_kbd_starved)
    );

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Grant selection and RAM mux. Everything is held quiet while RESET is
    // asserted so the outputs read as their reset values in that cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt        = REQ_NONE;
        ram_addr     = '0;
        ram_wdata    = '0;
        ram_we       = 1'b0;
        disp_ack     = 1'b0;
        kbd_ack      = 1'b0;
        w_beat_issue = 1'b0;
        w_beat_last  = 1'b0;
        if (!RESET) begin
            unique case (r_state)
                IDLE: begin
                    if (disp_req && w_disp_starved && kbd_req && w_kbd_starved)
                        w_gnt = r_rr_ptr;
                    else if (disp_req && w_disp_starved)
                        w_gnt = REQ_DISP;
                    else if (kbd_req && w_kbd_starved)
                        w_gnt = REQ_KBD;
                    else if (w_cpu_req)
                        w_gnt = REQ_CPU;
                    else if (disp_req && kbd_req)
                        w_gnt = r_rr_ptr;
                    else if (disp_req)
                        w_gnt = REQ_DISP;
                    else if (kbd_req)
                        w_gnt = REQ_KBD;

                    case (w_gnt)
                        REQ_CPU: begin
                            ram_addr  = cpu_addr;
                            ram_wdata = cpu_wdata;
                            ram_we    = cpu_we;    // re&we together is a write
                        end
                        REQ_DISP: begin
                            ram_addr     = disp_addr;
                            disp_ack     = 1'b1;
                            w_beat_issue = 1'b1;
                            w_beat_last  = (BURST_LEN == 1);
                            if (BURST_LEN > 1) w_state_nxt = BURST;
                        end
                        REQ_KBD: begin
                            ram_addr  = kbd_addr;
                            ram_wdata = kbd_wdata;
                            ram_we    = 1'b1;
                            kbd_ack   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                BURST: begin
                    // Address wraps naturally in AW bits.
                    ram_addr     = r_disp_addr + AW'(r_beat);
                    w_beat_issue = 1'b1;
                    w_beat_last  = (r_beat == BW'(BURST_LEN - 1));
                    if (w_beat_last) w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rr_ptr    <= REQ_DISP;
            r_beat      <= '0;
            r_disp_addr <= '0;
            r_rvalid    <= 1'b0;
            r_last      <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rvalid <= w_beat_issue;
            r_last   <= w_beat_last;
            if (w_beat_issue) r_rdata <= ram_rdata;
            if (w_disp_gnt || w_kbd_gnt)
                r_rr_ptr <= (r_rr_ptr == REQ_DISP) ? REQ_KBD : REQ_DISP;
            if (w_disp_gnt) begin
                r_disp_addr <= disp_addr;
                r_beat      <= (BURST_LEN > 1) ? BW'(1) : '0;
            end else if (r_state == BURST) begin
                r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
            end
        end
    end

    assign cpu_rdata   = ram_rdata;
    assign cpu_stall   = w_cpu_req & (w_gnt != REQ_CPU) & ~RESET;
    assign disp_rvalid = r_rvalid;
    assign disp_rdata  = r_rdata;
    assign disp_last   = r_last;
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    localparam int MW = 4;
    localparam int BL = 4;

    logic       CLK, RESET;
    logic       cpu_re, cpu_we, cpu_stall;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       disp_req, disp_ack, disp_rvalid, disp_last;
    logic [7:0] disp_addr, disp_rdata;
    logic       kbd_req, kbd_ack;
    logic [7:0] kbd_addr, kbd_wdata;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_we;

    dmem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(MW), .BURST_LEN(BL)) dut (
        .CLK(CLK), .RESET(RESET),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata), .disp_last(disp_last),
        .kbd_req(kbd_req), .kbd_addr(kbd_addr), .kbd_wdata(kbd_wdata), .kbd_ack(kbd_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // The RAM itself: async read, write on posedge; preset to addr^0x3C.
    logic [7:0] mem [256];
    logic       mem_init;
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_addr];

    typedef struct packed {
        logic rst, cre, cwe; logic [7:0] ca, cd;
        logic dreq; logic [7:0] da;
        logic kreq; logic [7:0] ka, kd;
    } in_t;
    typedef struct packed {
        logic we; logic [7:0] addr; logic stall, dack, kack, rv, last;
        logic [7:0] dd; logic crc; logic [7:0] crd;
    } exp_t;

    in_t  vi[$];
    exp_t ve[$];
    int   errs = 0, checks = 0, cyc = 0;

    // Reference model: ints for counters/pointer, a shadow memory, and a
    // "next beat index" that is nonzero while a burst is in flight.
    bit [7:0] sm [256];
    int m_wd, m_wk, m_rr, m_nb, m_base, m_g;
    bit m_rv, m_last; bit [7:0] m_rd;
    bit e_we, e_stall, e_dack, e_kack, e_iss, e_fin; bit [7:0] e_addr, e_wd;

    function automatic in_t mi(input bit rst, cre, cwe, input bit [7:0] ca, cd,
                               input bit dreq, input bit [7:0] da,
                               input bit kreq, input bit [7:0] ka, kd);
        return '{rst, cre, cwe, ca, cd, dreq, da, kreq, ka, kd};
    endfunction

    function automatic exp_t me(input bit we, input bit [7:0] addr, input bit stall, dack, kack, rv, last,
                                input bit [7:0] dd, input bit crc, input bit [7:0] crd);
        return '{we, addr, stall, dack, kack, rv, last, dd, crc, crd};
    endfunction

    task automatic add(input in_t i, input exp_t e);
        vi.push_back(i);
        ve.push_back(e);
    endtask

    function automatic void sm_init();
        for (int i = 0; i < 256; i++) sm[i] = 8'(i) ^ 8'h3C;
    endfunction

    function automatic void model_eval(input in_t v);
        bit cpu, fd, fk;
        int g;
        g = 0;
        e_we = 0; e_addr = 0; e_wd = 0; e_stall = 0; e_dack = 0; e_kack = 0; e_iss = 0; e_fin = 0;
        cpu = v.cre | v.cwe;
        if (!v.rst) begin
            if (m_nb != 0) begin
                e_addr = 8'((m_base + m_nb) % 256);
                e_iss  = 1;
                e_fin  = (m_nb == BL - 1);
            end else begin
                fd = v.dreq && (m_wd == MW);
                fk = v.kreq && (m_wk == MW);
                if (fd && fk)                g = (m_rr == 0) ? 2 : 3;
                else if (fd)                 g = 2;
                else if (fk)                 g = 3;
                else if (cpu)                g = 1;
                else if (v.dreq && v.kreq)   g = (m_rr == 0) ? 2 : 3;
                else if (v.dreq)             g = 2;
                else if (v.kreq)             g = 3;
            end
            e_stall = cpu && (g != 1);
            if (g == 1) begin e_addr = v.ca; e_we = v.cwe; e_wd = v.cd; end
            if (g == 2) begin e_addr = v.da; e_dack = 1; e_iss = 1; e_fin = (BL == 1); end
            if (g == 3) begin e_addr = v.ka; e_we = 1; e_wd = v.kd; e_kack = 1; end
        end
        m_g = g;
    endfunction

    function automatic void model_commit(input in_t v);
        if (v.rst) begin
            m_wd = 0; m_wk = 0; m_rr = 0; m_nb = 0; m_base = 0;
            m_rv = 0; m_last = 0; m_rd = 0;
        end else begin
            m_rv = e_iss; m_last = e_fin;
            if (e_iss) m_rd = sm[e_addr];
            if (e_we)  sm[e_addr] = e_wd;
            if (m_g == 2) m_wd = 0; else if (v.dreq && m_wd < MW) m_wd++;
            if (m_g == 3) m_wk = 0; else if (v.kreq && m_wk < MW) m_wk++;
            if (m_g >= 2) m_rr = 1 - m_rr;
            if (m_g == 2) begin
                m_base = int'(v.da);
                m_nb   = (BL > 1) ? 1 : 0;
            end else if (m_nb != 0) begin
                m_nb = e_fin ? 0 : m_nb + 1;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    // mode 0: drive only, 1: compare against table row, 2: compare against model
    task automatic step(input in_t v, input int mode, input exp_t t);
        @(negedge CLK);
        RESET = v.rst; cpu_re = v.cre; cpu_we = v.cwe; cpu_addr = v.ca; cpu_wdata = v.cd;
        disp_req = v.dreq; disp_addr = v.da; kbd_req = v.kreq; kbd_addr = v.ka; kbd_wdata = v.kd;
        #1;
        model_eval(v);
        if (mode == 1) begin
            chk("tab ram_we", {7'd0, ram_we}, {7'd0, t.we});
            chk("tab ram_addr", ram_addr, t.addr);
            chk("tab cpu_stall", {7'd0, cpu_stall}, {7'd0, t.stall});
            chk("tab disp_ack", {7'd0, disp_ack}, {7'd0, t.dack});
            chk("tab kbd_ack", {7'd0, kbd_ack}, {7'd0, t.kack});
            chk("tab disp_rvalid", {7'd0, disp_rvalid}, {7'd0, t.rv});
            chk("tab disp_last", {7'd0, disp_last}, {7'd0, t.last});
            if (t.rv)  chk("tab disp_rdata", disp_rdata, t.dd);
            if (t.crc) chk("tab cpu_rdata", cpu_rdata, t.crd);
        end else if (mode == 2) begin
            chk("mdl ram_we", {7'd0, ram_we}, {7'd0, e_we});
            chk("mdl ram_addr", ram_addr, e_addr);
            if (e_we) chk("mdl ram_wdata", ram_wdata, e_wd);
            chk("mdl cpu_stall", {7'd0, cpu_stall}, {7'd0, e_stall});
            chk("mdl disp_ack", {7'd0, disp_ack}, {7'd0, e_dack});
            chk("mdl kbd_ack", {7'd0, kbd_ack}, {7'd0, e_kack});
            chk("mdl disp_rvalid", {7'd0, disp_rvalid}, {7'd0, m_rv});
            chk("mdl disp_last", {7'd0, disp_last}, {7'd0, m_last});
            if (m_rv) chk("mdl disp_rdata", disp_rdata, m_rd);
            chk("mdl cpu_rdata", cpu_rdata, sm[e_addr]);
        end
        model_commit(v);
        cyc++;
    endtask

    initial begin
        in_t  idle, rst, v;
        exp_t z;
        bit dp, kp; bit [7:0] dpa, kpa, kpd; int dens;
        idle = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst  = mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        z    = me(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        RESET = 1'b1; mem_init = 1'b1;
        cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        disp_req = 0; disp_addr = 0; kbd_req = 0; kbd_addr = 0; kbd_wdata = 0;
        sm_init();
        step(rst, 0, z);
        step(rst, 0, z);
        mem_init = 1'b0;

        // Reset state, then CPU write/read
        add(idle, z);
        add(mi(0, 0, 1, 8'h10, 8'h5A, 0, 0, 0, 0, 0), me(1, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0));
        add(mi(0, 1, 0, 8'h10, 0, 0, 0, 0, 0, 0),     me(0, 8'h10, 0, 0, 0, 0, 0, 0, 1, 8'h5A));
        // CPU continuous with kbd held: forced slot on the 5th cycle, twice
        for (int k = 0; k < 4; k++)
            add(mi(0, 1, 0, 8'h20, 0, 0, 0, 1, 8'h30, 8'h77), me(0, 8'h20, 0, 0, 0, 0, 0, 0, 0, 0));
        add(mi(0, 1, 0, 8'h20, 0, 0, 0, 1, 8'h30, 8'h77),     me(1, 8'h30, 1, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            add(mi(0, 1, 0, 8'h20, 0, 0, 0, 1, 8'h31, 8'h66), me(0, 8'h20, 0, 0, 0, 0, 0, 0, 0, 0));
        add(mi(0, 1, 0, 8'h20, 0, 0, 0, 1, 8'h31, 8'h66),     me(1, 8'h31, 1, 0, 1, 0, 0, 0, 0, 0));
        add(mi(0, 1, 0, 8'h30, 0, 0, 0, 0, 0, 0),             me(0, 8'h30, 0, 0, 0, 0, 0, 0, 1, 8'h77));
        // Burst wrapping past 0xFF
        add(mi(0, 0, 0, 0, 0, 1, 8'hFE, 0, 0, 0), me(0, 8'hFE, 0, 1, 0, 0, 0, 0, 0, 0));
        add(idle, me(0, 8'hFF, 0, 0, 0, 1, 0, 8'hC2, 0, 0));
        add(idle, me(0, 8'h00, 0, 0, 0, 1, 0, 8'hC3, 0, 0));
        add(idle, me(0, 8'h01, 0, 0, 0, 1, 0, 8'h3C, 0, 0));
        add(idle, me(0, 8'h00, 0, 0, 0, 1, 1, 8'h3D, 0, 0));
        add(idle, z);
        // disp + kbd together from reset: disp first, kbd right after the burst
        add(rst, z);
        add(mi(0, 0, 0, 0, 0, 1, 8'h40, 1, 8'h50, 8'h11), me(0, 8'h40, 0, 1, 0, 0, 0, 0, 0, 0));
        add(mi(0, 0, 0, 0, 0, 0, 0, 1, 8'h50, 8'h11),     me(0, 8'h41, 0, 0, 0, 1, 0, 8'h7C, 0, 0));
        add(mi(0, 0, 0, 0, 0, 0, 0, 1, 8'h50, 8'h11),     me(0, 8'h42, 0, 0, 0, 1, 0, 8'h7D, 0, 0));
        add(mi(0, 0, 0, 0, 0, 0, 0, 1, 8'h50, 8'h11),     me(0, 8'h43, 0, 0, 0, 1, 0, 8'h7E, 0, 0));
        add(mi(0, 0, 0, 0, 0, 0, 0, 1, 8'h50, 8'h11),     me(1, 8'h50, 0, 0, 1, 1, 1, 8'h7F, 0, 0));
        add(idle, z);
        // CPU stalled by a burst, served the cycle after the last beat
        add(mi(0, 0, 0, 0, 0, 1, 8'h80, 0, 0, 0), me(0, 8'h80, 0, 1, 0, 0, 0, 0, 0, 0));
        add(mi(0, 1, 0, 8'h12, 0, 0, 0, 0, 0, 0), me(0, 8'h81, 1, 0, 0, 1, 0, 8'hBC, 0, 0));
        add(mi(0, 1, 0, 8'h12, 0, 0, 0, 0, 0, 0), me(0, 8'h82, 1, 0, 0, 1, 0, 8'hBD, 0, 0));
        add(mi(0, 1, 0, 8'h12, 0, 0, 0, 0, 0, 0), me(0, 8'h83, 1, 0, 0, 1, 0, 8'hBE, 0, 0));
        add(mi(0, 1, 0, 8'h12, 0, 0, 0, 0, 0, 0), me(0, 8'h12, 0, 0, 0, 1, 1, 8'hBF, 1, 8'h2E));
        add(idle, z);
        // RESET on beat 2 aborts the burst
        add(mi(0, 0, 0, 0, 0, 1, 8'h90, 0, 0, 0), me(0, 8'h90, 0, 1, 0, 0, 0, 0, 0, 0));
        add(idle, me(0, 8'h91, 0, 0, 0, 1, 0, 8'hAC, 0, 0));
        add(rst,  me(0, 8'h00, 0, 0, 0, 1, 0, 8'hAD, 0, 0));
        add(idle, z);
        add(idle, z);
        // re & we together is a write; read data still follows the RAM
        add(mi(0, 1, 1, 8'h10, 8'hC3, 0, 0, 0, 0, 0), me(1, 8'h10, 0, 0, 0, 0, 0, 0, 1, 8'h5A));
        add(mi(0, 1, 0, 8'h10, 0, 0, 0, 0, 0, 0),     me(0, 8'h10, 0, 0, 0, 0, 0, 0, 1, 8'hC3));

        for (int n = 0; n < vi.size(); n++) step(vi[n], 1, ve[n]);

        // Randomized traffic against the model, from a fresh reset and RAM image.
        mem_init = 1'b1;
        step(rst, 0, z);
        step(rst, 0, z);
        mem_init = 1'b0;
        sm_init();
        dp = 0; kp = 0; dpa = 0; kpa = 0; kpd = 0; dens = 2;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) dens = int'($urandom_range(0, 4));
            if (!dp && $urandom_range(0, 5) == 0) begin dp = 1; dpa = 8'($urandom); end
            if (!kp && $urandom_range(0, 4) == 0) begin kp = 1; kpa = 8'($urandom); kpd = 8'($urandom); end
            v.rst  = ($urandom_range(0, 299) == 0);
            v.cre  = ($urandom_range(0, 3) < dens);
            v.cwe  = ($urandom_range(0, 3) < dens) && $urandom_range(0, 1) == 1;
            v.ca   = 8'($urandom);
            v.cd   = 8'($urandom);
            v.dreq = dp; v.da = dpa;
            v.kreq = kp; v.ka = kpa; v.kd = kpd;
            step(v, 2, z);
            if (e_dack) dp = 0;
            if (e_kack) kp = 0;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
